// File: rtl/mcc_bus_cpu_pkg.sv
// mcc_bus_cpu_pkg: opcodes, FSM states, trap causes, store strobes and immediate extraction
// shared by the mcc_bus_cpu core and its control unit.
package mcc_bus_cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITE, S_HALT
  } state_t;

  localparam logic [2:0] TRAP_NONE       = 3'd0;
  localparam logic [2:0] TRAP_ILLEGAL    = 3'd1;
  localparam logic [2:0] TRAP_MISALIGN_D = 3'd2;
  localparam logic [2:0] TRAP_MISALIGN_T = 3'd3;
  localparam logic [2:0] TRAP_ECALL      = 3'd4;
  localparam logic [2:0] TRAP_EBREAK     = 3'd5;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  function automatic logic [31:0] imm_ext(input logic [31:0] i);
    return i[6:0] == OP_STORE  ? {{20{i[31]}}, i[31:25], i[11:7]} :
           i[6:0] == OP_BRANCH ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
           (i[6:0] == OP_LUI || i[6:0] == OP_AUIPC) ? {i[31:12], 12'd0} :
           i[6:0] == OP_JAL    ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
                                 {{20{i[31]}}, i[31:20]};
  endfunction

endpackage

// File: rtl/mcc_bus_control.sv
// mcc_bus_control: sequencing FSM, decode legality and trap detection for mcc_bus_cpu.
module mcc_bus_control import mcc_bus_cpu_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  f3,
  input  logic [11:0] sys_imm,
  input  logic        mem_ready,
  input  logic        taken,
  input  logic        tgt_b1,
  input  logic [1:0]  addr_lo,
  output state_t      state,
  output logic        mem_req,
  output logic        fetch_en,
  output logic        load_en,
  output logic        pc_load,
  output logic        reg_we,
  output logic        retire,
  output logic        trap,
  output logic [2:0]  cause
);

  state_t nxt;
  logic illegal, is_mem, branch, jump, redirect, misal;

  assign is_mem   = opcode == OP_LOAD || opcode == OP_STORE;
  assign branch   = opcode == OP_BRANCH;
  assign jump     = opcode == OP_JAL || opcode == OP_JALR;
  assign redirect = jump || (branch && taken);
  assign misal    = f3[1:0] == 2'd1 ? addr_lo[0] : f3[1:0] == 2'd2 ? |addr_lo : 1'b0;
  assign illegal  = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                     OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM}) ||
                    (opcode == OP_LOAD && (f3 == 3'd3 || f3[2:1] == 2'b11)) ||
                    (opcode == OP_STORE && f3 > 3'd2) ||
                    (branch && f3[2:1] == 2'b01);
  assign trap     = cause != TRAP_NONE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;

  always_comb begin
    nxt      = state;
    mem_req  = 1'b0;
    fetch_en = 1'b0;
    load_en  = 1'b0;
    pc_load  = 1'b0;
    reg_we   = 1'b0;
    retire   = 1'b0;
    cause    = TRAP_NONE;
    case (state)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        fetch_en = mem_ready;
        nxt      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        cause  = illegal ? TRAP_ILLEGAL : opcode != OP_SYSTEM ? TRAP_NONE :
                 sys_imm == 12'd0 ? TRAP_ECALL : sys_imm == 12'd1 ? TRAP_EBREAK : TRAP_ILLEGAL;
        retire = cause == TRAP_NONE && opcode == OP_FENCE;
        nxt    = cause != TRAP_NONE ? S_HALT : retire ? S_FETCH : S_EXECUTE;
      end
      S_EXECUTE: begin
        cause   = is_mem && misal ? TRAP_MISALIGN_D : redirect && tgt_b1 ? TRAP_MISALIGN_T : TRAP_NONE;
        pc_load = cause == TRAP_NONE && redirect;
        retire  = cause == TRAP_NONE && branch;
        nxt     = cause != TRAP_NONE ? S_HALT : is_mem ? S_MEM : branch ? S_FETCH : S_WRITE;
      end
      S_MEM: begin
        mem_req = 1'b1;
        retire  = mem_ready && opcode == OP_STORE;
        load_en = mem_ready && opcode == OP_LOAD;
        nxt     = retire ? S_FETCH : load_en ? S_WRITE : S_MEM;
      end
      S_WRITE: begin
        reg_we = 1'b1;
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      default: nxt = S_HALT;
    endcase
  end

endmodule

// File: rtl/mcc_bus_cpu.sv
// mcc_bus_cpu: multi-cycle RV32I core on a unified req/ready memory bus with precise
// trap/halt and a retired-instruction counter.
module mcc_bus_cpu import mcc_bus_cpu_pkg::*; #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          INSTRET_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  output logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata,
  output logic                 halted,
  output logic [2:0]           trap_cause,
  output logic [31:0]          trap_pc,
  output logic [INSTRET_W-1:0] instret
);

  state_t state;
  logic fetch_en, load_en, pc_load, reg_we, retire, trap, taken, sub;
  logic [2:0] cause;
  logic [31:0] pc, old_pc, instr, a, b, tgt_q, res, ld_q;
  logic [31:0] imm, rv1, rv2, op2, daddr, tgt, alu, ld_ext, wb;
  logic [31:0] regs [32];
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic [3:0] strb_base;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm    = imm_ext(instr);
  assign rv1    = rs1 == 5'd0 ? 32'd0 : regs[rs1];
  assign rv2    = rs2 == 5'd0 ? 32'd0 : regs[rs2];
  assign op2    = opcode == OP_OP ? b : imm;
  assign sub    = opcode == OP_OP && instr[30];
  assign daddr  = a + imm;
  assign tgt    = opcode == OP_JALR ? {daddr[31:1], 1'b0} : tgt_q;
  assign taken  = f3[2] ? ((f3[1] ? a < b : $signed(a) < $signed(b)) ^ f3[0]) : ((a == b) ^ f3[0]);

  always_comb begin
    alu = 32'd0;
    case (f3)
      3'd0: alu = sub ? a - op2 : a + op2;
      3'd1: alu = a << op2[4:0];
      3'd2: alu = {31'd0, $signed(a) < $signed(op2)};
      3'd3: alu = {31'd0, a < op2};
      3'd4: alu = a ^ op2;
      3'd5: alu = instr[30] ? 32'($signed(a) >>> op2[4:0]) : a >> op2[4:0];
      3'd6: alu = a | op2;
      default: alu = a & op2;
    endcase
  end

  // Unsigned loads have f3[2] set, which suppresses the sign fill.
  assign ld_ext = f3[1:0] == 2'd0 ? {{24{~f3[2] & ld_q[7]}}, ld_q[7:0]} :
                  f3[1:0] == 2'd1 ? {{16{~f3[2] & ld_q[15]}}, ld_q[15:0]} : ld_q;
  assign wb     = opcode == OP_LOAD ? ld_ext :
                  (opcode == OP_JAL || opcode == OP_JALR) ? old_pc + 32'd4 : res;

  assign strb_base = f3[1:0] == 2'd0 ? STRB_B : f3[1:0] == 2'd1 ? STRB_H : STRB_W;
  assign mem_wstrb = (state == S_MEM && opcode == OP_STORE) ? strb_base << daddr[1:0] : 4'd0;
  assign mem_wdata = f3[1:0] == 2'd0 ? {4{b[7:0]}} : f3[1:0] == 2'd1 ? {2{b[15:0]}} : b;
  assign mem_addr  = state == S_MEM ? daddr : pc;
  assign halted    = state == S_HALT;

  mcc_bus_control u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .f3       (f3),
    .sys_imm  (instr[31:20]),
    .mem_ready(mem_ready),
    .taken    (taken),
    .tgt_b1   (tgt[1]),
    .addr_lo  (daddr[1:0]),
    .state    (state),
    .mem_req  (mem_req),
    .fetch_en (fetch_en),
    .load_en  (load_en),
    .pc_load  (pc_load),
    .reg_we   (reg_we),
    .retire   (retire),
    .trap     (trap),
    .cause    (cause)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_VECTOR;
      old_pc     <= 32'd0;
      instr      <= 32'd0;
      a          <= 32'd0;
      b          <= 32'd0;
      tgt_q      <= 32'd0;
      res        <= 32'd0;
      ld_q       <= 32'd0;
      instret    <= '0;
      trap_cause <= TRAP_NONE;
      trap_pc    <= 32'd0;
    end else begin
      if (fetch_en) begin
        instr  <= mem_rdata;
        old_pc <= pc;
        pc     <= pc + 32'd4;
      end
      if (state == S_DECODE) begin
        a     <= rv1;
        b     <= rv2;
        tgt_q <= old_pc + imm;
      end
      if (state == S_EXECUTE) res <= opcode == OP_LUI ? imm : opcode == OP_AUIPC ? tgt_q : alu;
      if (pc_load) pc <= tgt;
      if (load_en) ld_q <= mem_rdata >> {daddr[1:0], 3'b000};
      if (retire) instret <= instret + INSTRET_W'(1);
      if (trap) begin
        trap_cause <= cause;
        trap_pc    <= old_pc;
      end
    end
  end

  always_ff @(posedge clk)
    if (reg_we && rd != 5'd0) regs[rd] <= wb;

endmodule
